// File: rtl/number_guess_main.sv
// Two-player number-guessing game controller driving a 16-character ASCII status line.
// Define SHOW_TRIES_EN to show the remaining tries in the last two characters while guessing.
module number_guess_main #(
    parameter int SYNC_STAGES    = 2,
    parameter int MAX_TRIES_ZERO = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         mode,
    input  logic         submit_N,
    input  logic         submit_M,
    input  logic [3:0]   timesIN,
    input  logic         submit2,
    input  logic         submit1,
    input  logic         button,
    input  logic [16:0]  data_buffer,
    output logic [127:0] status_string
);

`ifdef SHOW_TRIES_EN
    localparam bit SHOW_TRIES = 1'b1;
`else
    localparam bit SHOW_TRIES = 1'b0;
`endif

    localparam logic [127:0] MSG_ENTER_N     = "ENTER N         ";
    localparam logic [127:0] MSG_ENTER_GUESS = "ENTER GUESS     ";
    localparam logic [127:0] MSG_INVALID     = "INVALID         ";
    localparam logic [127:0] MSG_CORRECT     = "CORRECT         ";
    localparam logic [127:0] MSG_TOO_HIGH    = "TOO HIGH        ";
    localparam logic [127:0] MSG_TOO_LOW     = "TOO LOW         ";
    localparam logic [127:0] MSG_GAME_OVER   = "GAME OVER       ";

    typedef enum logic [1:0] {IDLE, GUESS, WIN, LOSE} state_t;

    state_t      state;
    logic [15:0] secret;
    logic [4:0]  limit;
    logic [4:0]  used;

    // Bit order: {mode, button, submit1, submit2, submit_M, submit_N}
    logic [5:0] raw_in;
    logic [5:0] sync_q [SYNC_STAGES];
    logic [5:0] synced;
    logic [2:0] prev_q;

    assign raw_in = {mode, button, submit1, submit2, submit_M, submit_N};
    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
            prev_q <= '1;
        end else begin
            sync_q[0] <= raw_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= {synced[4], synced[1], synced[0]};
        end
    end

    logic n_ev, m_ev, btn_ev, mode_s, sub2_s, sub1_s;
    assign n_ev   = prev_q[0] & ~synced[0];
    assign m_ev   = prev_q[1] & ~synced[1];
    assign btn_ev = prev_q[2] & ~synced[4];
    assign sub2_s = synced[2];
    assign sub1_s = synced[3];
    assign mode_s = synced[5];

    function automatic logic valid_bcd(input logic [16:0] d);
        return d[16] && (d[15:12] <= 4'd9) && (d[11:8] <= 4'd9) &&
               (d[7:4] <= 4'd9) && (d[3:0] <= 4'd9);
    endfunction

    // Unlimited games show "--"; limit never exceeds 16, so one tens digit suffices.
    function automatic logic [127:0] with_tries(input logic [127:0] msg,
                                                input logic [4:0] rem,
                                                input logic limited);
        logic [4:0]  ones;
        logic [15:0] digits;
        ones   = (rem >= 5'd10) ? rem - 5'd10 : rem;
        digits = limited ? {((rem >= 5'd10) ? 8'h31 : 8'h30), 8'h30 + {3'b000, ones}} : "--";
        return SHOW_TRIES ? {msg[127:16], digits} : msg;
    endfunction

    logic [4:0] used_next;
    logic [4:0] rem_next;
    logic [4:0] limit_new;
    logic       entry_valid;

    always_comb begin
        used_next   = (mode_s || used < 5'd15) ? used + 5'd1 : used;
        rem_next    = (limit > used_next) ? limit - used_next : 5'd0;
        limit_new   = (timesIN == 4'd0) ? 5'(MAX_TRIES_ZERO) : {1'b0, timesIN};
        entry_valid = valid_bcd(data_buffer);
    end

    // Restart outranks everything; otherwise only the current state's own event is honoured.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            status_string <= MSG_ENTER_N;
            secret        <= '0;
            limit         <= '0;
            used          <= '0;
        end else if (btn_ev) begin
            state         <= IDLE;
            status_string <= MSG_ENTER_N;
            limit         <= '0;
            used          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (n_ev && !sub2_s) begin
                        if (entry_valid) begin
                            secret        <= data_buffer[15:0];
                            limit         <= limit_new;
                            used          <= '0;
                            state         <= GUESS;
                            status_string <= with_tries(MSG_ENTER_GUESS, limit_new, mode_s);
                        end else begin
                            status_string <= MSG_INVALID;
                        end
                    end
                end
                GUESS: begin
                    if (m_ev && !sub1_s) begin
                        if (!entry_valid) begin
                            status_string <= MSG_INVALID;
                        end else if (data_buffer[15:0] == secret) begin
                            state         <= WIN;
                            status_string <= MSG_CORRECT;
                        end else begin
                            used <= used_next;
                            if (mode_s && used_next >= limit) begin
                                state         <= LOSE;
                                status_string <= MSG_GAME_OVER;
                            end else if (data_buffer[15:0] > secret) begin
                                status_string <= with_tries(MSG_TOO_HIGH, rem_next, mode_s);
                            end else begin
                                status_string <= with_tries(MSG_TOO_LOW, rem_next, mode_s);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_number_guess_main.sv
// Table-driven scoreboard bench for number_guess_main: each vector presses one button,
// queues the expected status line and compares it three clock edges later.
module tb_number_guess_main;

    logic         clk = 1'b0;
    logic         reset;
    logic         mode;
    logic         submit_N, submit_M, submit2, submit1, button;
    logic [3:0]   timesIN;
    logic [16:0]  data_buffer;
    logic [127:0] status_string;

    int checks = 0;
    int passes = 0;

    number_guess_main dut (
        .clk          (clk),
        .reset        (reset),
        .mode         (mode),
        .submit_N     (submit_N),
        .submit_M     (submit_M),
        .timesIN      (timesIN),
        .submit2      (submit2),
        .submit1      (submit1),
        .button       (button),
        .data_buffer  (data_buffer),
        .status_string(status_string)
    );

    always #5 clk = ~clk;

    // kind: 0 = submit_N with submit2, 1 = submit_M with submit1, 2 = restart, 3 = submit_M alone
    typedef struct {
        logic [1:0]   kind;
        logic         mode_v;
        logic [3:0]   times_v;
        logic [16:0]  data_v;
        logic [127:0] base;
        logic [15:0]  tries;
    } vec_t;

    vec_t         vecs[$];
    logic [127:0] exp_q[$];

    function automatic logic [127:0] exp_str(input logic [127:0] base, input logic [15:0] tries);
`ifdef SHOW_TRIES_EN
        return {base[127:16], tries};
`else
        return (tries == tries) ? base : base;
`endif
    endfunction

    function automatic vec_t mk(input logic [1:0] k, input logic m, input logic [3:0] t,
                                input logic [16:0] d, input logic [127:0] b, input logic [15:0] tr);
        vec_t v;
        v.kind = k; v.mode_v = m; v.times_v = t; v.data_v = d; v.base = b; v.tries = tr;
        return v;
    endfunction

    task automatic checkOutput(input string tag);
        logic [127:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            $display("[TB] FAIL %s: scoreboard empty, got \"%s\"", tag, status_string);
        end else begin
            exp = exp_q.pop_front();
            if (status_string !== exp)
                $display("[TB] FAIL %s: got \"%s\" required \"%s\"", tag, status_string, exp);
            else
                passes++;
        end
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        @(negedge clk);
        mode        = v.mode_v;
        timesIN     = v.times_v;
        data_buffer = v.data_v;
        repeat (3) @(negedge clk);
        case (v.kind)
            2'd0:    begin submit_N = 1'b0; submit2 = 1'b0; end
            2'd1:    begin submit_M = 1'b0; submit1 = 1'b0; end
            2'd2:    button = 1'b0;
            default: submit_M = 1'b0;
        endcase
        exp_q.push_back(exp_str(v.base, v.tries));
        repeat (3) @(posedge clk);
        #1;
        checkOutput(tag);
        @(negedge clk);
        {submit_N, submit_M, submit2, submit1, button} = '1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got \"%s\"", status_string);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vecs.push_back(mk(0, 1, 5, 17'h10010, "ENTER GUESS     ", "05"));
        vecs.push_back(mk(1, 1, 5, 17'h10015, "TOO HIGH        ", "04"));
        vecs.push_back(mk(1, 1, 5, 17'h10007, "TOO LOW         ", "03"));
        vecs.push_back(mk(1, 1, 5, 17'h0001A, "INVALID         ", "  "));
        vecs.push_back(mk(1, 1, 5, 17'h00015, "INVALID         ", "  "));
        vecs.push_back(mk(1, 1, 5, 17'h1A000, "INVALID         ", "  "));
        vecs.push_back(mk(3, 1, 5, 17'h10010, "INVALID         ", "  "));
        vecs.push_back(mk(1, 1, 5, 17'h10009, "TOO LOW         ", "02"));
        vecs.push_back(mk(1, 1, 5, 17'h10011, "TOO HIGH        ", "01"));
        vecs.push_back(mk(1, 1, 5, 17'h10012, "GAME OVER       ", "  "));
        vecs.push_back(mk(1, 1, 5, 17'h10010, "GAME OVER       ", "  "));
        vecs.push_back(mk(0, 1, 5, 17'h10010, "GAME OVER       ", "  "));
        vecs.push_back(mk(2, 1, 5, 17'h10010, "ENTER N         ", "  "));
        vecs.push_back(mk(1, 1, 5, 17'h10010, "ENTER N         ", "  "));
        vecs.push_back(mk(0, 0, 0, 17'h0001A, "INVALID         ", "  "));
        vecs.push_back(mk(0, 0, 0, 17'h10010, "ENTER GUESS     ", "--"));
        vecs.push_back(mk(1, 0, 0, 17'h10015, "TOO HIGH        ", "--"));
        vecs.push_back(mk(1, 0, 0, 17'h10007, "TOO LOW         ", "--"));
        vecs.push_back(mk(1, 0, 0, 17'h10020, "TOO HIGH        ", "--"));
        vecs.push_back(mk(1, 0, 0, 17'h10001, "TOO LOW         ", "--"));
        vecs.push_back(mk(1, 0, 0, 17'h10099, "TOO HIGH        ", "--"));
        vecs.push_back(mk(0, 0, 0, 17'h10005, "TOO HIGH        ", "--"));
        vecs.push_back(mk(1, 0, 0, 17'h10010, "CORRECT         ", "  "));
        vecs.push_back(mk(1, 0, 0, 17'h10015, "CORRECT         ", "  "));
        vecs.push_back(mk(2, 0, 0, 17'h10015, "ENTER N         ", "  "));
        vecs.push_back(mk(0, 1, 0, 17'h10123, "ENTER GUESS     ", "16"));
        vecs.push_back(mk(1, 1, 0, 17'h10000, "TOO LOW         ", "15"));
        vecs.push_back(mk(1, 0, 0, 17'h10200, "TOO HIGH        ", "--"));
        vecs.push_back(mk(2, 0, 0, 17'h10200, "ENTER N         ", "  "));
        vecs.push_back(mk(0, 1, 1, 17'h10500, "ENTER GUESS     ", "01"));
        vecs.push_back(mk(1, 1, 1, 17'h10499, "GAME OVER       ", "  "));
        vecs.push_back(mk(2, 1, 1, 17'h10499, "ENTER N         ", "  "));

        reset = 1'b1;
        mode = 1'b1; timesIN = 4'd0; data_buffer = '0;
        {submit_N, submit_M, submit2, submit1, button} = '1;
        repeat (3) @(negedge clk);
        exp_q.push_back("ENTER N         ");
        checkOutput("reset_held");
        reset = 1'b0;
        repeat (4) @(negedge clk);
        exp_q.push_back("ENTER N         ");
        checkOutput("reset_released");

        foreach (vecs[i]) applyStimulus(vecs[i], $sformatf("vec%0d", i));

        // Asynchronous reset mid-game must clear the line without waiting for a clock edge.
        applyStimulus(mk(0, 1, 3, 17'h10042, "ENTER GUESS     ", "03"), "pre_reset_secret");
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        exp_q.push_back("ENTER N         ");
        checkOutput("async_reset");
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(mk(1, 1, 3, 17'h10042, "ENTER N         ", "  "), "guess_after_reset");
        applyStimulus(mk(0, 1, 3, 17'h10042, "ENTER GUESS     ", "03"), "secret_after_reset");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
